// File: rtl/ptp_slave_exchange.sv
`default_nettype none
// ============================================================================
// Module   : ptp_slave_exchange
// Purpose  : Slave-side PTP exchange sequencer. Turns sync / delay-response
//            strobes from the packet path into a delay-request trigger and
//            the four-timestamp strobes used by the clock-synchronisation
//            block. Idle while the node is master (m_or_s = 1).
// Ports    : clk, reset (async, active low)
//            m_or_s              1 = master (block held idle), 0 = slave
//            timer[47:0]         local time {ms, cyc}, cyc wraps at 124999
//            rx_sync_valid/ts    sync received, carries t1
//            tx_req_done         delay-request has left the port
//            rx_resp_valid/ts    delay-response received, carries t4
//            send_req_pkt        one-cycle delay-request trigger
//            ts_1_valid/ts_1     t1 strobe and value
//            ts_2_record         downstream latches its timer as t2
//            ts_3_valid/ts_3     t3 strobe and value
//            ts_4_valid/ts_4     t4 strobe and value
//            status_ok           all four timestamps valid
//            timeout_err         exchange aborted (timeout / bad timestamp)
//            overrun_err         sync restarted an open exchange
//            exch_cnt[31:0]      completed exchanges, wrapping
// Options  : PTP_TS_RANGE_CHECK_EN - reject t1/t4 whose cycle field > 124999
// Revision : 1.0 - initial release
// ============================================================================
module ptp_slave_exchange #(
    parameter logic [16:0] RESP_TIMEOUT = 17'd124999,
    parameter logic [7:0]  REQ_GAP      = 8'd16
) (
    input  wire         clk,
    input  wire         reset,
    input  wire         m_or_s,
    input  wire  [47:0] timer,
    input  wire         rx_sync_valid,
    input  wire  [47:0] rx_sync_ts,
    input  wire         tx_req_done,
    input  wire         rx_resp_valid,
    input  wire  [47:0] rx_resp_ts,
    output logic        send_req_pkt,
    output logic        ts_1_valid,
    output logic [47:0] ts_1,
    output logic        ts_2_record,
    output logic        ts_3_valid,
    output logic [47:0] ts_3,
    output logic        ts_4_valid,
    output logic [47:0] ts_4,
    output logic        status_ok,
    output logic        timeout_err,
    output logic        overrun_err,
    output logic [31:0] exch_cnt
);

    localparam logic [2:0]  c_ST_IDLE      = 3'd0;
    localparam logic [2:0]  c_ST_GAP       = 3'd1;
    localparam logic [2:0]  c_ST_REQ       = 3'd2;
    localparam logic [2:0]  c_ST_WAIT_TX   = 3'd3;
    localparam logic [2:0]  c_ST_WAIT_RESP = 3'd4;
    localparam logic [2:0]  c_ST_DONE      = 3'd5;
    localparam logic [16:0] c_CYC_MAX      = 17'd124999;

    logic [2:0]  r_state;
    logic [7:0]  r_gap_cnt;
    logic [16:0] r_to_cnt;
    logic        r_send, r_ts1_v, r_ts2_rec, r_ts3_v, r_ts4_v;
    logic        r_ok, r_tout, r_ovr;
    logic [47:0] r_ts_1, r_ts_3, r_ts_4;
    logic [31:0] r_exch_cnt;

    logic [2:0]  w_state_nxt;
    logic [7:0]  w_gap_nxt;
    logic [16:0] w_to_nxt;
    logic        w_send, w_ts1_v, w_ts3_v, w_ts4_v, w_ok, w_tout, w_ovr;
    logic        w_t1_bad, w_t4_bad;

`ifdef PTP_TS_RANGE_CHECK_EN
    assign w_t1_bad = (rx_sync_ts[16:0] > c_CYC_MAX);
    assign w_t4_bad = (rx_resp_ts[16:0] > c_CYC_MAX);
`else
    assign w_t1_bad = 1'b0;
    assign w_t4_bad = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_to_nxt    = r_to_cnt;
        w_send      = 1'b0;
        w_ts1_v     = 1'b0;
        w_ts3_v     = 1'b0;
        w_ts4_v     = 1'b0;
        w_ok        = 1'b0;
        w_tout      = 1'b0;
        w_ovr       = 1'b0;
        if (m_or_s) begin
            // Master node: drop any open exchange, never strobe.
            w_state_nxt = c_ST_IDLE;
        end else if (rx_sync_valid) begin
            // A sync always (re)starts the exchange, beating any
            // simultaneous tx-done / response or a pending timeout.
            w_ovr = (r_state != c_ST_IDLE);
            if (w_t1_bad) begin
                w_tout      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end else begin
                w_ts1_v     = 1'b1;
                // GAP lasts REQ_GAP cycles: counts REQ_GAP-1 down to 0.
                w_gap_nxt   = REQ_GAP - 8'd1;
                w_state_nxt = c_ST_GAP;
            end
        end else begin
            case (r_state)
                c_ST_IDLE: ;
                c_ST_GAP: begin
                    if (r_gap_cnt == 8'd0) w_state_nxt = c_ST_REQ;
                    else                   w_gap_nxt   = r_gap_cnt - 8'd1;
                end
                c_ST_REQ: begin
                    w_send      = 1'b1;
                    w_to_nxt    = 17'd0;
                    w_state_nxt = c_ST_WAIT_TX;
                end
                c_ST_WAIT_TX: begin
                    // One counter spans both wait states.
                    w_to_nxt = r_to_cnt + 17'd1;
                    if (r_to_cnt == RESP_TIMEOUT) begin
                        w_tout      = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else if (tx_req_done) begin
                        w_ts3_v     = 1'b1;
                        w_state_nxt = c_ST_WAIT_RESP;
                    end
                end
                c_ST_WAIT_RESP: begin
                    w_to_nxt = r_to_cnt + 17'd1;
                    if (r_to_cnt == RESP_TIMEOUT) begin
                        w_tout      = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end else if (rx_resp_valid) begin
                        if (w_t4_bad) begin
                            w_tout      = 1'b1;
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_ts4_v     = 1'b1;
                            w_state_nxt = c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    w_ok        = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_gap_cnt  <= 8'd0;
            r_to_cnt   <= 17'd0;
            r_send     <= 1'b0;
            r_ts1_v    <= 1'b0;
            r_ts2_rec  <= 1'b0;
            r_ts3_v    <= 1'b0;
            r_ts4_v    <= 1'b0;
            r_ok       <= 1'b0;
            r_tout     <= 1'b0;
            r_ovr      <= 1'b0;
            r_ts_1     <= 48'd0;
            r_ts_3     <= 48'd0;
            r_ts_4     <= 48'd0;
            r_exch_cnt <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_to_cnt  <= w_to_nxt;
            r_send    <= w_send;
            r_ts1_v   <= w_ts1_v;
            r_ts2_rec <= w_ts1_v;
            r_ts3_v   <= w_ts3_v;
            r_ts4_v   <= w_ts4_v;
            r_ok      <= w_ok;
            r_tout    <= w_tout;
            r_ovr     <= w_ovr;
            if (w_ts1_v) r_ts_1     <= rx_sync_ts;
            if (w_ts3_v) r_ts_3     <= timer;
            if (w_ts4_v) r_ts_4     <= rx_resp_ts;
            if (w_ok)    r_exch_cnt <= r_exch_cnt + 32'd1;
        end
    end

    assign send_req_pkt = r_send;
    assign ts_1_valid   = r_ts1_v;
    assign ts_1         = r_ts_1;
    assign ts_2_record  = r_ts2_rec;
    assign ts_3_valid   = r_ts3_v;
    assign ts_3         = r_ts_3;
    assign ts_4_valid   = r_ts4_v;
    assign ts_4         = r_ts_4;
    assign status_ok    = r_ok;
    assign timeout_err  = r_tout;
    assign overrun_err  = r_ovr;
    assign exch_cnt     = r_exch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ptp_slave_exchange.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptp_slave_exchange
// Purpose  : Scoreboard bench for ptp_slave_exchange. Stimulus pushes the
//            expected strobes (kind, cycle, value) into a queue; a monitor
//            on the falling edge pops and compares whatever the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptp_slave_exchange;

    localparam int c_T = 60;   // shortened response timeout
    localparam int c_G = 16;   // request gap

    localparam int K_OVR = 0, K_TOUT = 1, K_TS1 = 2, K_T2 = 3;
    localparam int K_REQ = 4, K_TS3 = 5, K_TS4 = 6, K_OK = 7;

    logic        clk = 1'b0;
    logic        reset, m_or_s;
    logic [47:0] timer, rx_sync_ts, rx_resp_ts;
    logic        rx_sync_valid, tx_req_done, rx_resp_valid;
    logic        send_req_pkt, ts_1_valid, ts_2_record, ts_3_valid, ts_4_valid;
    logic        status_ok, timeout_err, overrun_err;
    logic [47:0] ts_1, ts_3, ts_4;
    logic [31:0] exch_cnt;

    ptp_slave_exchange #(
        .RESP_TIMEOUT (17'(c_T)),
        .REQ_GAP      (8'(c_G))
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_or_s        (m_or_s),
        .timer         (timer),
        .rx_sync_valid (rx_sync_valid),
        .rx_sync_ts    (rx_sync_ts),
        .tx_req_done   (tx_req_done),
        .rx_resp_valid (rx_resp_valid),
        .rx_resp_ts    (rx_resp_ts),
        .send_req_pkt  (send_req_pkt),
        .ts_1_valid    (ts_1_valid),
        .ts_1          (ts_1),
        .ts_2_record   (ts_2_record),
        .ts_3_valid    (ts_3_valid),
        .ts_3          (ts_3),
        .ts_4_valid    (ts_4_valid),
        .ts_4          (ts_4),
        .status_ok     (status_ok),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err),
        .exch_cnt      (exch_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [47:0] data;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [30:0] tm_ms;
    logic [16:0] tm_cy;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    task automatic chk(input int kind, input logic strobe, input logic [47:0] act,
                       input string name);
        int idx;
        idx = -1;
        if (strobe !== 1'b1) return;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].kind == kind) begin
                idx = i;
                break;
            end
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL %s: unexpected strobe at cycle %0d value %h", name, cyc, act);
        end else begin
            if (q[idx].cyc != cyc || q[idx].data !== act) begin
                errors++;
                $display("FAIL %s: got cycle %0d value %h, expected cycle %0d value %h",
                         name, cyc, act, q[idx].cyc, q[idx].data);
            end
            q.delete(idx);
        end
    endtask

    always @(negedge clk) begin
        chk(K_OVR,  overrun_err,  48'd0,            "overrun_err");
        chk(K_TOUT, timeout_err,  48'd0,            "timeout_err");
        chk(K_TS1,  ts_1_valid,   ts_1,             "ts_1");
        chk(K_T2,   ts_2_record,  48'd0,            "ts_2_record");
        chk(K_REQ,  send_req_pkt, 48'd0,            "send_req_pkt");
        chk(K_TS3,  ts_3_valid,   ts_3,             "ts_3");
        chk(K_TS4,  ts_4_valid,   ts_4,             "ts_4");
        chk(K_OK,   status_ok,    {16'd0, exch_cnt}, "status_ok/exch_cnt");
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing strobe kind %0d: expected at cycle %0d value %h, now cycle %0d",
                         q[i].kind, q[i].cyc, q[i].data, cyc);
                q.delete(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input int kind, input int c, input logic [47:0] d);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        q.push_back(e);
    endtask

    function automatic logic [47:0] rand_ts();
        logic [16:0] cy;
        logic [30:0] ms;
        cy = 17'($urandom_range(0, 124999));
        ms = 31'($urandom());
        return {ms, cy};
    endfunction

    // Advance one cycle: pulses drop, local time ticks with cyc wrap.
    task automatic step();
        @(posedge clk);
        #1;
        rx_sync_valid = 1'b0;
        tx_req_done   = 1'b0;
        rx_resp_valid = 1'b0;
        if (tm_cy == 17'd124999) begin
            tm_cy = 17'd0;
            tm_ms = tm_ms + 31'd1;
        end else begin
            tm_cy = tm_cy + 17'd1;
        end
        timer = {tm_ms, tm_cy};
    endtask

    // Step until cycle 'target', optionally adding pulses that must be ignored.
    task automatic goto(input int target, input bit ntx, input bit nresp);
        while (cyc < target) begin
            step();
            if (ntx && $urandom_range(0, 3) == 0) tx_req_done = 1'b1;
            if (nresp && $urandom_range(0, 3) == 0) begin
                rx_resp_valid = 1'b1;
                rx_resp_ts    = rand_ts();
            end
        end
    endtask

    task automatic begin_sync(input bit ovr, output int n);
        logic [47:0] t1;
        t1            = rand_ts();
        rx_sync_valid = 1'b1;
        rx_sync_ts    = t1;
        n             = cyc;
        push(K_TS1, n + 1, t1);
        push(K_T2,  n + 1, 48'd0);
        if (ovr) push(K_OVR, n + 1, 48'd0);
    endtask

    task automatic master_burst(input int len);
        m_or_s = 1'b1;
        repeat (len) begin
            step();
            if ($urandom_range(0, 2) == 0) begin
                rx_sync_valid = 1'b1;
                rx_sync_ts    = rand_ts();
            end
            if ($urandom_range(0, 2) == 0) tx_req_done = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                rx_resp_valid = 1'b1;
                rx_resp_ts    = rand_ts();
            end
        end
        step();
        m_or_s = 1'b0;
    endtask

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk_eq({tag, " strobes"}, 64'({send_req_pkt, ts_1_valid, ts_2_record, ts_3_valid,
                                      ts_4_valid, status_ok, timeout_err, overrun_err}), 64'd0);
        chk_eq({tag, " ts_1"}, 64'(ts_1), 64'd0);
        chk_eq({tag, " ts_3"}, 64'(ts_3), 64'd0);
        chk_eq({tag, " ts_4"}, 64'(ts_4), 64'd0);
        chk_eq({tag, " exch_cnt"}, 64'(exch_cnt), 64'd0);
    endtask

    // mode: 0 nominal, 1 timeout, 2 overrun in WAIT_RESP, 3 overrun in GAP/REQ,
    //       4 master mid-exchange, 5 out-of-range t4
    task automatic exchange(input int mode_in);
        int          n, w, m, k, s, x, md;
        bit          restart;
        logic [47:0] t4;
        md = mode_in;
        goto(cyc + 1, 1'b0, 1'b0);
        begin_sync(1'b0, n);
        restart = 1'b1;
        while (restart) begin
            restart = 1'b0;
            w = n + 2 + c_G;    // send_req_pkt cycle, first WAIT_TX cycle
            if (md == 3) begin
                s = n + int'($urandom_range(1, c_G + 1));
                goto(s, 1'b1, 1'b1);
                begin_sync(1'b1, n);
                md      = 0;
                restart = 1'b1;
            end else begin
                push(K_REQ, w, 48'd0);
                goto(w - 1, 1'b1, 1'b1);
                if (md == 1 && $urandom_range(0, 1) == 0) begin
                    push(K_TOUT, w + c_T + 1, 48'd0);
                    goto(w + c_T + 3, 1'b0, 1'b0);
                end else begin
                    m = w + int'($urandom_range(0, c_T - 3));
                    goto(m, 1'b0, 1'b1);
                    tx_req_done = 1'b1;
                    push(K_TS3, m + 1, timer);
                    case (md)
                        1: begin
                            push(K_TOUT, w + c_T + 1, 48'd0);
                            goto(w + c_T + 3, 1'b1, 1'b0);
                        end
                        2: begin
                            s = m + 1 + int'($urandom_range(0, w + c_T - 1 - (m + 1)));
                            goto(s, 1'b1, 1'b0);
                            begin_sync(1'b1, n);
                            if ($urandom_range(0, 1) == 0) begin
                                rx_resp_valid = 1'b1;
                                rx_resp_ts    = rand_ts();
                            end
                            md      = 0;
                            restart = 1'b1;
                        end
                        4: begin
                            x = m + 2 + int'($urandom_range(0, w + c_T - 1 - (m + 2)));
                            goto(x, 1'b1, 1'b0);
                            master_burst(int'($urandom_range(3, 20)));
                        end
                        default: begin
                            k = m + 1 + int'($urandom_range(0, w + c_T - 1 - (m + 1)));
                            goto(k, 1'b1, 1'b0);
                            t4 = (md == 5) ? {31'($urandom()), 17'd125000} : rand_ts();
                            rx_resp_valid = 1'b1;
                            rx_resp_ts    = t4;
`ifdef PTP_TS_RANGE_CHECK_EN
                            if (md == 5) begin
                                push(K_TOUT, k + 1, 48'd0);
                            end else begin
                                push(K_TS4, k + 1, t4);
                                exp_cnt = exp_cnt + 32'd1;
                                push(K_OK, k + 2, {16'd0, exp_cnt});
                            end
`else
                            push(K_TS4, k + 1, t4);
                            exp_cnt = exp_cnt + 32'd1;
                            push(K_OK, k + 2, {16'd0, exp_cnt});
`endif
                            goto(k + 2 + int'($urandom_range(1, 3)), 1'b1, 1'b1);
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic reset_mid();
        int n, w, m;
        goto(cyc + 1, 1'b0, 1'b0);
        begin_sync(1'b0, n);
        w = n + 2 + c_G;
        push(K_REQ, w, 48'd0);
        m = w + 3;
        goto(m, 1'b0, 1'b0);
        tx_req_done = 1'b1;
        push(K_TS3, m + 1, timer);
        goto(m + 4, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid-exchange reset");
        q.delete();
        exp_cnt = 32'd0;
        step();
        step();
        reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset         = 1'b0;
        m_or_s        = 1'b0;
        rx_sync_valid = 1'b0;
        tx_req_done   = 1'b0;
        rx_resp_valid = 1'b0;
        rx_sync_ts    = 48'd0;
        rx_resp_ts    = 48'd0;
        tm_ms         = 31'd5;
        tm_cy         = 17'd124900;
        timer         = {tm_ms, tm_cy};
        repeat (3) step();
        check_zero("reset");
        reset = 1'b1;
        step();
        step();
        master_burst(25);
        exchange(0);
        exchange(5);
        exchange(1);
        exchange(2);
        exchange(3);
        exchange(4);
        repeat (40) exchange(int'($urandom_range(0, 5)));
        reset_mid();
        exchange(0);
        exchange(0);
        goto(cyc + 5, 1'b0, 1'b0);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d expected strobes outstanding, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
